dram_port_arbiter: RTL
======================

Name: dram_port_arbiter

Overview:
- Shares the single external cached-memory port between the I-cache refill path (read-only) and the D-cache refill/write-back path (read/write).
- Sits between the I/D caches and the M_DMEM-style memory controller port of the Aquila IP wrapper.
- Applies round-robin arbitration on contention and holds each grant for a whole cache-line transaction.
- Registers all memory-side outputs.

Parameters:
- XLEN, 32, address width in bits.
- CLSIZE, 128, cache-line data width in bits.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- i_strobe_i  in  1  I-cache request; level, held until i_done_o.
- i_addr_i  in  XLEN  I-cache line address.
- i_done_o  out  1  one-cycle pulse: I transaction complete, i_data_o valid.
- i_data_o  out  CLSIZE  line read for the I-cache.
- d_strobe_i  in  1  D-cache request; level, held until d_done_o.
- d_addr_i  in  XLEN  D-cache line address.
- d_rw_i  in  1  1 = write-back, 0 = refill.
- d_data_i  in  CLSIZE  write-back line.
- d_done_o  out  1  one-cycle pulse: D transaction complete.
- d_data_o  out  CLSIZE  line read for the D-cache.
- m_strobe_o  out  1  memory request, held until m_done_i.
- m_addr_o  out  XLEN  memory address.
- m_rw_o  out  1  memory direction.
- m_data_o  out  CLSIZE  write data to memory.
- m_done_i  in  1  memory completion pulse.
- m_data_i  in  CLSIZE  read data; valid when m_done_i = 1.
- busy_o  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE. Reset state is IDLE.
- Reset values: all outputs 0; last_grant = I.
- IDLE arbitration, evaluated on strobes sampled at cycle t:
  - Only i_strobe_i high -> GRANT_I.
  - Only d_strobe_i high -> GRANT_D.
  - Both high -> grant the side opposite last_grant. After reset, D wins the first tie.
- On the grant edge, latch the selected side's addr, rw and data into m_addr_o, m_rw_o and m_data_o. I grants force m_rw_o = 0 and m_data_o = 0. m_strobe_o = 1 from cycle t+1. Update last_grant.
- GRANT_x: m_strobe_o, m_addr_o, m_rw_o and m_data_o stay stable; requester inputs are ignored.
- m_done_i = 1 at cycle k in GRANT_x:
  - Cycle k+1: m_strobe_o = 0; x_done_o = 1 for exactly one cycle; for reads, x_data_o = m_data_i captured at k.
  - FSM -> RELEASE at k+1, then IDLE at k+2.
  - RELEASE gives the requester one cycle to drop its strobe, so a stale strobe is never re-granted.
- x_data_o holds its last captured value until the next completion on that side. d_data_o is not updated on D writes.
- m_done_i in IDLE or RELEASE is ignored: no done pulse, no state change.
- Minimum turnaround is request at t -> m_strobe_o at t+1 -> done pulse at m_done_i cycle +1. Back-to-back grants are therefore at least 2 cycles apart after a done.
- A requester dropping its strobe mid-grant is illegal. The arbiter still completes the transaction and pulses done.
- Reset asserted mid-transaction: at the next edge, state = IDLE, m_strobe_o = 0, done pulses suppressed. A late m_done_i is then ignored.
- Fairness: under continuous requests from both sides, grants alternate D, I, D, I, ...
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- I read: i_strobe_i = 1, i_addr_i = 0x8000_0040 at t0; memory answers m_done_i at t0+5 with data 0xDEAD…BEEF -> m_strobe_o high t0+1..t0+5 with m_rw_o = 0; i_done_o pulses once at t0+6 with that data; busy_o low at t0+7.
- D write-back: d_rw_i = 1, addr 0x8000_1000, data pattern P -> m_rw_o = 1, m_data_o = P for the whole grant; d_done_o pulses once; d_data_o unchanged.
- Simultaneous strobes from reset, addresses 0x8000_0000 (I) and 0x8000_2000 (D) -> D served first, then I, with no overlap of m_strobe_o and ≥1 RELEASE cycle between grants.
- Both requesters continuously re-requesting for 6 transactions -> grant order D, I, D, I, D, I.
- rst_i pulsed during GRANT_D, followed by m_done_i 2 cycles later -> no d_done_o; m_strobe_o = 0 from the cycle after reset; a subsequent I request is served normally.
- m_done_i pulsed while IDLE -> all outputs remain 0; FSM stays IDLE.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Shares one cached-memory port between the I-cache refill path and the
// D-cache refill/write-back path, granting whole line transactions.
//
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   i_strobe_i/addr_i  I-cache read request (level, held until i_done_o)
//   i_done_o/data_o    I completion pulse and returned line
//   d_strobe_i/addr_i  D-cache request; d_rw_i=1 write-back with d_data_i
//   d_done_o/data_o    D completion pulse and returned line (reads only)
//   m_*                registered memory-side request, m_done_i/m_data_i reply
//   busy_o             high whenever the arbiter is not idle
module dram_port_arbiter #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_strobe_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_done_o,
  output logic [CLSIZE-1:0] i_data_o,
  input  logic              d_strobe_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic              d_rw_i,
  input  logic [CLSIZE-1:0] d_data_i,
  output logic              d_done_o,
  output logic [CLSIZE-1:0] d_data_o,
  output logic              m_strobe_o,
  output logic [XLEN-1:0]   m_addr_o,
  output logic              m_rw_o,
  output logic [CLSIZE-1:0] m_data_o,
  input  logic              m_done_i,
  input  logic [CLSIZE-1:0] m_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_t;

  state_t state_q, state_d;

  // 1 = the most recent grant went to D
  logic last_d_q, last_d_d;

  logic              m_strobe_q, m_strobe_d;
  logic [XLEN-1:0]   m_addr_q, m_addr_d;
  logic              m_rw_q, m_rw_d;
  logic [CLSIZE-1:0] m_data_q, m_data_d;
  logic              i_done_q, i_done_d;
  logic [CLSIZE-1:0] i_data_q, i_data_d;
  logic              d_done_q, d_done_d;
  logic [CLSIZE-1:0] d_data_q, d_data_d;
  logic              busy_q, busy_d;

  logic pick_i, pick_d;

  // On a tie the side that did not win last time is chosen.
  always_comb begin
    pick_i = i_strobe_i & (~d_strobe_i | last_d_q);
    pick_d = d_strobe_i & (~i_strobe_i | ~last_d_q);
  end

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    m_strobe_d = m_strobe_q;
    m_addr_d   = m_addr_q;
    m_rw_d     = m_rw_q;
    m_data_d   = m_data_q;
    i_done_d   = 1'b0;
    i_data_d   = i_data_q;
    d_done_d   = 1'b0;
    d_data_d   = d_data_q;

    case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_i: begin
            state_d    = GRANT_I;
            last_d_d   = 1'b0;
            m_strobe_d = 1'b1;
            m_addr_d   = i_addr_i;
            m_rw_d     = 1'b0;
            m_data_d   = '0;
          end
          pick_d: begin
            state_d    = GRANT_D;
            last_d_d   = 1'b1;
            m_strobe_d = 1'b1;
            m_addr_d   = d_addr_i;
            m_rw_d     = d_rw_i;
            m_data_d   = d_data_i;
          end
          default: ;
        endcase
      end
      GRANT_I: begin
        if (m_done_i) begin
          state_d    = RELEASE;
          m_strobe_d = 1'b0;
          i_done_d   = 1'b1;
          i_data_d   = m_data_i;
        end
      end
      GRANT_D: begin
        if (m_done_i) begin
          state_d    = RELEASE;
          m_strobe_d = 1'b0;
          d_done_d   = 1'b1;
          // write-backs return nothing worth keeping
          if (!m_rw_q) begin
            d_data_d = m_data_i;
          end
        end
      end
      // One dead cycle lets the finished requester drop its strobe.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      m_strobe_q <= 1'b0;
      m_addr_q   <= '0;
      m_rw_q     <= 1'b0;
      m_data_q   <= '0;
      i_done_q   <= 1'b0;
      i_data_q   <= '0;
      d_done_q   <= 1'b0;
      d_data_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      m_strobe_q <= m_strobe_d;
      m_addr_q   <= m_addr_d;
      m_rw_q     <= m_rw_d;
      m_data_q   <= m_data_d;
      i_done_q   <= i_done_d;
      i_data_q   <= i_data_d;
      d_done_q   <= d_done_d;
      d_data_q   <= d_data_d;
      busy_q     <= busy_d;
    end
  end

  assign m_strobe_o = m_strobe_q;
  assign m_addr_o   = m_addr_q;
  assign m_rw_o     = m_rw_q;
  assign m_data_o   = m_data_q;
  assign i_done_o   = i_done_q;
  assign i_data_o   = i_data_q;
  assign d_done_o   = d_done_q;
  assign d_data_o   = d_data_q;
  assign busy_o     = busy_q;

endmodule
